pal_cfg_loader: RTL and testbench
=================================

# pal_cfg_loader

Configuration loader for the PAL fabric's configuration shift-register chain. Accepts configuration bytes over a valid/ready stream and clears the chain. Serialises exactly LEN bits into it, MSB first, generating the chain's clock, reset and enable. Asserts the enable only once the full bitstream is in place, so the fabric never sees a partial configuration.

## Interface
Parameters:
- LEN, default 64: number of configuration bits in the chain (≥1; any value, not restricted to multiples of 8).
- CNT_W, default $clog2(LEN+1): width of the internal bit counter (derived; do not override).

Ports:
- clk, input, 1: system clock. One clock; all logic on posedge.
- res, input, 1: reset, synchronous, active-high.
- start, input, 1: begin a (re)configuration; sampled in IDLE or DONE only, ignored otherwise.
- din, input, 8: configuration byte; bit 7 is shifted first.
- din_valid, input, 1: din holds a byte.
- din_ready, output, 1: loader accepts din this cycle. A transfer occurs when din_valid and din_ready are both high.
- sr_cfg, output, 1: serial data to the chain's cfg input.
- sr_clk, output, 1: registered clock to the chain (one rising edge per bit).
- sr_res_n, output, 1: active-low reset to the chain.
- sr_en, output, 1: apply configuration to the fabric.
- busy, output, 1: high in any state other than IDLE and DONE.
- done, output, 1: configuration complete; equals sr_en.

## Operation
- All outputs are registered.
- States: IDLE, CLR_LO, CLR_HI, WAIT_BYTE, SH_LO, SH_HI, DONE.
- IDLE: sr_clk=0, sr_res_n=1, sr_en=0, din_ready=0.
  - start → CLR_LO.
- CLR_LO: sr_res_n=0, sr_clk=0 → CLR_HI.
- CLR_HI: sr_res_n=0, sr_clk=1. This edge synchronously clears the chain.
  - Load bit counter = LEN.
  - → WAIT_BYTE.
- WAIT_BYTE: sr_res_n=1, sr_clk=0, din_ready=1.
  - On transfer: latch din into an 8-bit byte register and set the byte-bit index to 7.
  - → SH_LO.
- SH_LO: sr_cfg = byte_reg[index], sr_clk=0 → SH_HI.
  - sr_cfg is set here and held through SH_HI, so it is stable around the sr_clk rising edge.
- SH_HI: sr_clk=1, sr_cfg held. Decrement the bit counter and the index.
  - Counter reaches 0 → DONE.
  - Else if index was 0 → WAIT_BYTE.
  - Else → SH_LO.
- DONE: sr_clk=0, sr_res_n=1, sr_en=1, done=1.
  - start → CLR_LO; sr_en and done drop in the first CLR_LO cycle.
- Bit order:
  - The first bit shifted ends at chain position LEN-1; the last bit ends at position 0.
  - Bytes are consumed in order, bit 7 first.
  - If LEN mod 8 = k ≠ 0, only bits 7..8-k of the final byte are shifted. Its remaining bits are discarded, and no extra byte is requested.
- The loader requests exactly ceil(LEN/8) bytes per configuration.
- din_valid with din_ready low is ignored and not buffered.
- start while busy is ignored.
- The chain itself is never reset by `res`. During and after `res`, sr_en=0 masks the fabric.

## Timing
- Reset values: state IDLE; sr_cfg=0, sr_clk=0, sr_res_n=1, sr_en=0, done=0, busy=0, din_ready=0.
- Reset mid-load returns to IDLE on the next edge. The partial chain contents are masked by sr_en=0.
- Start: start sampled high at edge N puts the loader in CLR_LO during cycle N+1.
- Per-bit cost: 2 cycles.
- Per-byte overhead: at least 1 WAIT_BYTE cycle. Stalls extend WAIT_BYTE indefinitely; sr_clk stays 0 during stalls.
- Minimum latency, start edge to sr_en=1: 3 + 2·LEN + ceil(LEN/8) cycles, with din_valid held high.
  - For LEN=8 this is 20 cycles.
- sr_clk high time is exactly 1 cycle; its minimum period is 2 cycles.
- sr_res_n is low for exactly 2 cycles (CLR_LO, CLR_HI), with one sr_clk rising edge in CLR_HI.
- busy rises the cycle after start is sampled and falls on the same edge that raises done.

## Test plan
- Reset: assert res 3 cycles in any state → all outputs equal the reset values above; sr_en=0.
- Basic load, LEN=8: start, din=0xA5 held valid → one transfer, then sr_cfg sequence 1,0,1,0,0,1,0,1 on sr_clk rising edges. Chain model holds 0xA5; sr_en=1 exactly 20 cycles after the start edge.
- Partial byte, LEN=12: bytes 0x3C, 0xF0 → exactly 2 transfers, 12 sr_clk edges, chain = 0x3CF; no third din_ready.
- Stalls: LEN=16, din_valid low for 5 cycles before each byte → sr_clk idles low while stalled, chain correct, done delayed by exactly 10 cycles vs. no stall.
- Reconfigure and ignored start: start during load has no effect. start in DONE → sr_en drops next cycle, sr_res_n pulses low 2 cycles, chain cleared before the new bits arrive.
- Reset mid-load: res after 5 bits of a LEN=8 load → IDLE next edge; sr_en=0; a fresh start then completes a correct load.

Source files
------------

// File: rtl/pal_cfg_loader.sv
// rtl/pal_cfg_loader.sv - serial loader for the PAL configuration shift-register chain
//
// Clears the chain, then shifts exactly LEN bits into it (MSB of each byte first)
// and raises sr_en only once the complete bitstream is in place.
//
// Ports:
//   clk, res         system clock, synchronous active-high reset
//   start            begin a (re)configuration; honoured only in IDLE or DONE
//   din/din_valid    configuration byte stream input
//   din_ready        byte accepted when din_valid && din_ready
//   sr_cfg           serial data to the chain
//   sr_clk           generated chain clock (one rising edge per bit)
//   sr_res_n         active-low synchronous clear for the chain
//   sr_en            apply configuration to the fabric
//   busy             loader active (not IDLE / DONE)
//   done             configuration complete (mirrors sr_en)
module pal_cfg_loader #(
  parameter int LEN   = 64,
  parameter int CNT_W = $clog2(LEN + 1)
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       sr_cfg,
  output logic       sr_clk,
  output logic       sr_res_n,
  output logic       sr_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    CLR_LO,
    CLR_HI,
    WAIT_BYTE,
    SH_LO,
    SH_HI,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;   // bits still to shift for this configuration
  logic [7:0]       byte_reg;
  logic [2:0]       idx;       // bit of byte_reg currently on sr_cfg

  // Every output is a register updated on the transition into the state that
  // owns its value, so the chain sees glitch-free sr_clk / sr_res_n.
  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      byte_reg  <= '0;
      idx       <= '0;
      sr_cfg    <= 1'b0;
      sr_clk    <= 1'b0;
      sr_res_n  <= 1'b1;
      sr_en     <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      din_ready <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= CLR_LO;
            sr_res_n <= 1'b0;
            sr_clk   <= 1'b0;
            sr_en    <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b1;
          end
        end

        CLR_LO: begin
          // Rising sr_clk while sr_res_n is low clears the chain.
          state  <= CLR_HI;
          sr_clk <= 1'b1;
        end

        CLR_HI: begin
          state     <= WAIT_BYTE;
          sr_clk    <= 1'b0;
          sr_res_n  <= 1'b1;
          bit_cnt   <= CNT_W'(LEN);
          din_ready <= 1'b1;
        end

        WAIT_BYTE: begin
          if (din_valid && din_ready) begin
            state     <= SH_LO;
            byte_reg  <= din;
            idx       <= 3'd7;
            sr_cfg    <= din[7];   // data set up a full cycle before sr_clk rises
            din_ready <= 1'b0;
          end
        end

        SH_LO: begin
          state  <= SH_HI;
          sr_clk <= 1'b1;
        end

        SH_HI: begin
          sr_clk  <= 1'b0;
          bit_cnt <= bit_cnt - CNT_W'(1);
          idx     <= idx - 3'd1;
          if (bit_cnt == CNT_W'(1)) begin
            // Last bit: any unused low bits of a partial final byte are dropped.
            state <= DONE;
            sr_en <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (idx == 3'd0) begin
            state     <= WAIT_BYTE;
            din_ready <= 1'b1;
          end else begin
            state  <= SH_LO;
            sr_cfg <= byte_reg[idx - 3'd1];
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// tb/tb_pal_cfg_loader.sv - scoreboard bench for pal_cfg_loader (LEN = 8, 12, 16 instances)
module tb_pal_cfg_loader;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  logic       start_s     [3];
  logic       din_valid_s [3];
  logic [7:0] din_s       [3];
  logic       din_ready_s [3];
  logic       sr_cfg_s    [3];
  logic       sr_clk_s    [3];
  logic       sr_res_n_s  [3];
  logic       sr_en_s     [3];
  logic       busy_s      [3];
  logic       done_s      [3];

  // Scoreboard: expected serial bits and expected final chain per instance.
  bit          exp_bits  [3][$];
  logic [63:0] exp_chain [3][$];

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic int lenof(input int g);
    return (g == 0) ? 8 : ((g == 1) ? 12 : 16);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int L = (g == 0) ? 8 : ((g == 1) ? 12 : 16);

    pal_cfg_loader #(.LEN(L)) dut (
      .clk      (clk),
      .res      (res),
      .start    (start_s[g]),
      .din      (din_s[g]),
      .din_valid(din_valid_s[g]),
      .din_ready(din_ready_s[g]),
      .sr_cfg   (sr_cfg_s[g]),
      .sr_clk   (sr_clk_s[g]),
      .sr_res_n (sr_res_n_s[g]),
      .sr_en    (sr_en_s[g]),
      .busy     (busy_s[g]),
      .done     (done_s[g])
    );

    // Chain model plus monitor, sampled on the falling clock edge.
    logic [L-1:0] chain = '0;
    logic         prev_clk = 1'b0;
    logic         prev_done = 1'b0;
    int           shifted = 0;
    int           xfers = 0;
    bit           b;

    always @(negedge clk) begin
      if (din_valid_s[g] && din_ready_s[g]) xfers++;
      if (sr_clk_s[g] && !prev_clk) begin
        if (!sr_res_n_s[g]) begin
          check($sformatf("u%0d sr_en_during_clear", g), sr_en_s[g], 0);
          chain   = '0;
          shifted = 0;
          xfers   = 0;
        end else begin
          check($sformatf("u%0d bit_expected", g), exp_bits[g].size() != 0, 1);
          if (exp_bits[g].size() != 0) begin
            b = exp_bits[g].pop_front();
            check($sformatf("u%0d sr_cfg_bit%0d", g, shifted), sr_cfg_s[g], b);
          end
          chain = {chain[L-2:0], sr_cfg_s[g]};
          shifted++;
        end
      end
      if (done_s[g] && !prev_done) begin
        check($sformatf("u%0d edges", g), shifted, L);
        check($sformatf("u%0d transfers", g), xfers, (L + 7) / 8);
        check($sformatf("u%0d sr_en_eq_done", g), sr_en_s[g], 1);
        check($sformatf("u%0d busy_at_done", g), busy_s[g], 0);
        check($sformatf("u%0d ready_at_done", g), din_ready_s[g], 0);
        check($sformatf("u%0d bits_left", g), exp_bits[g].size(), 0);
        check($sformatf("u%0d chain_expected", g), exp_chain[g].size() != 0, 1);
        if (exp_chain[g].size() != 0)
          check($sformatf("u%0d chain", g), 64'(chain), exp_chain[g].pop_front());
      end
      prev_clk  = sr_clk_s[g];
      prev_done = done_s[g];
    end
  end

  task automatic check_idle(input int g, input string tag);
    check($sformatf("u%0d %s", g, tag),
          {sr_cfg_s[g], sr_clk_s[g], sr_res_n_s[g], sr_en_s[g], done_s[g], busy_s[g], din_ready_s[g]},
          7'b0010000);
  endtask

  // One full configuration: pushes expectations, then feeds bytes while
  // measuring start-to-done latency in cycles (cycle 1 = first after start edge).
  task automatic load(input int g, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [63:0] chain_exp, input int stall, input int lat_exp, input bit poke);
    int         len;
    logic [7:0] bytes [2];
    len      = lenof(g);
    bytes[0] = b0;
    bytes[1] = b1;
    for (int i = 0; i < len; i++) exp_bits[g].push_back(bytes[i / 8][7 - (i % 8)]);
    exp_chain[g].push_back(chain_exp);
    start_s[g] = 1'b1;
    tick();
    start_s[g] = 1'b0;
    fork
      begin
        for (int k = 0; k < (len + 7) / 8; k++) begin
          int  w;
          bit  seen;
          w    = 0;
          seen = 0;
          din_s[g] = bytes[k];
          if (stall == 0) din_valid_s[g] = 1'b1;
          while (w < 200 && !seen) begin
            @(negedge clk);
            w++;
            if (din_ready_s[g]) seen = 1;
          end
          check($sformatf("u%0d ready_byte%0d", g, k), seen, 1);
          repeat (stall) tick();
          din_valid_s[g] = 1'b1;
          tick();
          din_valid_s[g] = 1'b0;
        end
      end
      begin
        int n;
        bit fin;
        n   = 0;
        fin = 0;
        while (n < 400 && !fin) begin
          @(negedge clk);
          n++;
          if (n == 1)
            check($sformatf("u%0d clr_lo", g),
                  {sr_res_n_s[g], sr_clk_s[g], sr_en_s[g], done_s[g], busy_s[g]}, 5'b00001);
          if (n == 2)
            check($sformatf("u%0d clr_hi", g), {sr_res_n_s[g], sr_clk_s[g]}, 2'b01);
          if (n == 3)
            check($sformatf("u%0d wait_byte", g), {sr_res_n_s[g], sr_clk_s[g], din_ready_s[g]}, 3'b101);
          if (done_s[g]) fin = 1;
        end
        check($sformatf("u%0d latency", g), n, lat_exp);
      end
      begin
        if (poke) begin
          repeat (12) tick();
          start_s[g] = 1'b1;
          tick();
          start_s[g] = 1'b0;
        end
      end
    join
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w;
    for (int g = 0; g < 3; g++) begin
      start_s[g]     = 1'b0;
      din_valid_s[g] = 1'b0;
      din_s[g]       = 8'h00;
    end
    res = 1'b1;
    repeat (3) tick();
    for (int g = 0; g < 3; g++) check_idle(g, "reset");
    res = 1'b0;
    tick();

    // LEN=8 basic: 0xA5, 20 cycles to done
    load(0, 8'hA5, 8'h00, 64'hA5, 0, 20, 0);
    // LEN=12 partial byte: 0x3C, 0xF0 -> 0x3CF
    load(1, 8'h3C, 8'hF0, 64'h3CF, 0, 29, 0);
    // LEN=16, start poked mid-load must be ignored
    load(2, 8'h12, 8'h34, 64'h1234, 0, 37, 1);
    check("u2 still_done", done_s[2], 1);
    // LEN=16 reconfigure from DONE with 5-cycle stalls: +10 cycles
    load(2, 8'hBE, 8'hEF, 64'hBEEF, 5, 47, 0);

    // Reset after 5 bits of a LEN=8 load
    for (int i = 0; i < 8; i++) exp_bits[0].push_back(1'(8'h5A >> (7 - i)));
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    din_s[0]       = 8'h5A;
    din_valid_s[0] = 1'b1;
    w = 0;
    while (exp_bits[0].size() > 3 && w < 200) begin
      tick();
      w++;
    end
    din_valid_s[0] = 1'b0;
    check("u0 five_bits", exp_bits[0].size(), 3);
    check("u0 busy_mid", busy_s[0], 1);
    res = 1'b1;
    tick();
    @(negedge clk);
    check_idle(0, "reset_mid_load");
    repeat (2) tick();
    for (int g = 0; g < 3; g++) check_idle(g, "reset_hold");
    res = 1'b0;
    exp_bits[0].delete();
    tick();
    load(0, 8'hC3, 8'h00, 64'hC3, 0, 20, 0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
